// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the apb_mem_array scratch-memory subsystem.
// Holds the per-transfer FSM state type, decode helpers and error codes.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_RANGE = 3'd1;
  localparam logic [2:0] ERR_ALIGN = 3'd2;
  localparam logic [2:0] ERR_STRB  = 3'd3;

  // Number of paddr bits that address a byte within one data word.
  function automatic int byte_off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// One APB memory bank: transfer FSM, wait counter, address decode and byte-lane memory.
// Optional macro APB_PSTRB_EN enables byte-strobe writes.
module apb_mem_bank
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = byte_off_bits(DATA_WIDTH);
  localparam int IW  = idx_bits(DEPTH);
  localparam int AIW = ADDR_WIDTH - OFF;
  localparam logic [AIW:0] DEPTH_LIM = (AIW + 1)'(DEPTH);
  localparam logic [3:0]   WS = 4'(WAIT_STATES);

  apb_state_e state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       complete;
  logic       do_write;
  logic [2:0] err_code;
  logic [AIW-1:0] word_addr;
  logic [IW-1:0]  mem_idx;
  logic [NB-1:0]  wr_bytes;
  logic [DATA_WIDTH-1:0] rd_word;

  assign word_addr = paddr[ADDR_WIDTH-1:OFF];
  assign mem_idx   = word_addr[IW-1:0];

`ifdef APB_PSTRB_EN
  assign wr_bytes = pstrb;
`else
  logic unused_pstrb;
  assign wr_bytes     = '1;
  assign unused_pstrb = ^pstrb;
`endif

  always_comb begin
    err_code = ERR_NONE;
    if (paddr[OFF-1:0] != '0) begin
      err_code = ERR_ALIGN;
    end else if ({1'b0, word_addr} >= DEPTH_LIM) begin
      err_code = ERR_RANGE;
    end
`ifdef APB_PSTRB_EN
    else if (pwrite && (pstrb == '0)) begin
      err_code = ERR_STRB;
    end
`endif
  end

  // The SETUP-state cycle is already the first access cycle on the bus, so the
  // counter is loaded with one less than the wait count when entering ACCESS.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    complete   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (sel && !penable) state_next = SETUP;
      end
      SETUP: begin
        if (sel && penable) begin
          if (WS == 4'd0) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next   = WS - 4'd1;
            state_next = ACCESS;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (sel && penable) begin
          if (cnt_reg == 4'd0) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign do_write = complete && pwrite && (err_code == ERR_NONE) && !rst;

  // One byte-wide array per lane so strobed writes map onto lane enables.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int w = 0; w < DEPTH; w++) lane_mem[w] <= '0;
        rd_byte_reg <= '0;
      end else begin
        if (do_write && wr_bytes[gi]) lane_mem[mem_idx] <= pwdata[gi*8 +: 8];
        rd_byte_reg <= lane_mem[mem_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = rd_byte_reg;
  end

  assign pready  = complete;
  assign pslverr = complete && (err_code != ERR_NONE);
  assign prdata  = (complete && !pwrite && (err_code == ERR_NONE)) ? rd_word : '0;

endmodule

// File: rtl/apb_mem_array.sv
// NUM_SLAVES APB memory banks on one bus with one-hot select check and output OR-mux.
// Optional macro APB_PSTRB_EN enables byte-strobe writes in every bank.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SLAVES-1:0]   psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic one_hot;
  logic multi_sel;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] bank_ready;
  logic [NUM_SLAVES-1:0] bank_err;

  assign one_hot   = $onehot(psel);
  assign multi_sel = (psel != '0) && !one_hot;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_bank
    apb_mem_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .WAIT_STATES(WAIT_STATES)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .sel    (psel[gi] && one_hot),
      .penable(penable),
      .paddr  (paddr),
      .pwrite (pwrite),
      .pwdata (pwdata),
      .pstrb  (pstrb),
      .prdata (bank_rdata[gi]),
      .pready (bank_ready[gi]),
      .pslverr(bank_err[gi])
    );
  end

  // Error responder for multi-bit selects: mirrors the bank handshake timing.
  apb_state_e err_state_reg, err_state_next;
  logic [3:0] err_cnt_reg, err_cnt_next;
  logic       err_complete;

  always_comb begin
    err_state_next = err_state_reg;
    err_cnt_next   = err_cnt_reg;
    err_complete   = 1'b0;
    unique case (err_state_reg)
      IDLE: begin
        err_cnt_next = '0;
        if (multi_sel && !penable) err_state_next = SETUP;
      end
      SETUP: begin
        if (multi_sel && penable) begin
          if (WS == 4'd0) begin
            err_complete   = 1'b1;
            err_state_next = IDLE;
          end else begin
            err_cnt_next   = WS - 4'd1;
            err_state_next = ACCESS;
          end
        end else begin
          err_state_next = IDLE;
        end
      end
      ACCESS: begin
        if (multi_sel && penable) begin
          if (err_cnt_reg == 4'd0) begin
            err_complete   = 1'b1;
            err_state_next = IDLE;
          end else begin
            err_cnt_next = err_cnt_reg - 4'd1;
          end
        end else begin
          err_state_next = IDLE;
        end
      end
      default: err_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_state_reg <= IDLE;
      err_cnt_reg   <= '0;
    end else begin
      err_state_reg <= err_state_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  always_comb begin
    prdata  = '0;
    pready  = err_complete;
    pslverr = err_complete;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel[i]) begin
        prdata  = prdata | bank_rdata[i];
        pready  = pready | bank_ready[i];
        pslverr = pslverr | bank_err[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_array.sv
// Self-checking bench for apb_mem_array: a WAIT_STATES=2 instance for most checks and a
// WAIT_STATES=0 instance for two-cycle latency; covers APB_PSTRB_EN when defined.
module tb_apb_mem_array;

  localparam int NS    = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS-1:0]   bus_psel;
  logic            bus_penable;
  logic [AW-1:0]   bus_paddr;
  logic            bus_pwrite;
  logic [DW-1:0]   bus_pwdata;
  logic [DW/8-1:0] bus_pstrb;
  bit              use_fast;

  logic [NS-1:0] psel_m, psel_f;
  logic [DW-1:0] prdata_m, prdata_f;
  logic          pready_m, pready_f, pslverr_m, pslverr_f;
  logic [DW-1:0] mon_prdata;
  logic          mon_pready, mon_pslverr;

  assign psel_m      = use_fast ? '0 : bus_psel;
  assign psel_f      = use_fast ? bus_psel : '0;
  assign mon_prdata  = use_fast ? prdata_f : prdata_m;
  assign mon_pready  = use_fast ? pready_f : pready_m;
  assign mon_pslverr = use_fast ? pslverr_f : pslverr_m;

  apb_mem_array #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                  .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .psel(psel_m), .penable(bus_penable), .paddr(bus_paddr),
    .pwrite(bus_pwrite), .pwdata(bus_pwdata), .pstrb(bus_pstrb),
    .prdata(prdata_m), .pready(pready_m), .pslverr(pslverr_m));

  apb_mem_array #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                  .WAIT_STATES(0)) u_dut_fast (
    .clk(clk), .rst(rst), .psel(psel_f), .penable(bus_penable), .paddr(bus_paddr),
    .pwrite(bus_pwrite), .pwdata(bus_pwdata), .pstrb(bus_pstrb),
    .prdata(prdata_f), .pready(pready_f), .pslverr(pslverr_f));

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Reference memory: [instance][bank][word]
  logic [DW-1:0] mdl [2][NS][DEPTH];

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  addr;
    bit          wr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NS; b++)
        for (int w = 0; w < DEPTH; w++) mdl[d][b][w] = '0;
  endfunction

  function automatic void model_xfer(input int d, input logic [3:0] sel, input logic [7:0] addr,
                                     input bit wr, input logic [31:0] wd, input logic [3:0] st,
                                     output logic [31:0] rd, output bit er);
    int b;
    int idx;
    rd = '0;
    er = 1'b0;
    b = 0;
    if ($countones(sel) != 1) begin
      er = 1'b1;
      return;
    end
    for (int k = 0; k < NS; k++) if (sel[k]) b = k;
    if ((int'(addr) % 4 != 0) || (int'(addr) / 4 >= DEPTH)) begin
      er = 1'b1;
      return;
    end
    idx = int'(addr) / 4;
    if (!wr) begin
      rd = mdl[d][b][idx];
    end else begin
`ifdef APB_PSTRB_EN
      if (st == 4'h0) begin
        er = 1'b1;
        return;
      end
      for (int k = 0; k < 4; k++) if (st[k]) mdl[d][b][idx][8*k +: 8] = wd[8*k +: 8];
`else
      if (st == 4'hF || st != 4'hF) mdl[d][b][idx] = wd;
`endif
    end
  endfunction

  // Entered and left #1 after a rising edge; leaving the bus driven allows back-to-back.
  task automatic xfer(input logic [3:0] sel, input logic [7:0] addr, input bit wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output bit er, output int lat);
    bit done;
    bus_psel = sel; bus_penable = 1'b0; bus_paddr = addr;
    bus_pwrite = wr; bus_pwdata = wd; bus_pstrb = st;
    @(posedge clk); #1;
    bus_penable = 1'b1;
    lat = 0; rd = '0; er = 1'b0; done = 1'b0;
    while (!done && lat < 40) begin
      lat++;
      @(negedge clk);
      if (mon_pready) begin
        rd = mon_prdata;
        er = mon_pslverr;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) lat = -1;
    n_txn++;
    $display("txn %0d dut=%0s psel=%b addr=%h wr=%0d wdata=%h strb=%b -> rdata=%h err=%0d lat=%0d",
             n_txn, use_fast ? "ws0" : "ws2", sel, addr, wr, wd, st, rd, er, lat);
  endtask

  task automatic idle(input int n);
    bus_psel = '0; bus_penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic [3:0] sel, input logic [7:0] addr,
                         input bit wr, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] e_rd, rd;
    bit e_err, er;
    int lat;
    model_xfer(use_fast ? 1 : 0, sel, addr, wr, wd, st, e_rd, e_err);
    xfer(sel, addr, wr, wd, st, rd, er, lat);
    check({tag, "_rdata"}, rd, e_rd);
    check({tag, "_err"}, 32'(er), 32'(e_err));
    check({tag, "_lat"}, 32'(lat), use_fast ? 32'd1 : 32'(WS + 1));
  endtask

  initial begin
    logic [31:0] rd, e_rd;
    bit er, e_err;
    int lat;
    logic [3:0] rsel;
    logic [7:0] raddr;
    int pick;
    logic [3:0] multi_tbl [5];

    multi_tbl[0] = 4'b0101; multi_tbl[1] = 4'b0011; multi_tbl[2] = 4'b1111;
    multi_tbl[3] = 4'b0110; multi_tbl[4] = 4'b1010;

    tbl[0]  = '{4'b0001, 8'h04, 1'b0, 32'h0,        4'hF, 32'h0,        1'b0};
    tbl[1]  = '{4'b0100, 8'h08, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[2]  = '{4'b0100, 8'h08, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{4'b0100, 8'h40, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1};
    tbl[4]  = '{4'b0100, 8'h02, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1};
    tbl[5]  = '{4'b0100, 8'h08, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{4'b0101, 8'h08, 1'b1, 32'h12345678, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{4'b0001, 8'h08, 1'b0, 32'h0,        4'hF, 32'h0,        1'b0};
    tbl[8]  = '{4'b0100, 8'h08, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{4'b0010, 8'h3C, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[10] = '{4'b0010, 8'h3C, 1'b0, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{4'b0010, 8'h40, 1'b1, 32'h55555555, 4'hF, 32'h0,        1'b1};
    tbl[12] = '{4'b0110, 8'h3C, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1};
    tbl[13] = '{4'b1000, 8'h00, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    tbl[14] = '{4'b1000, 8'h00, 1'b0, 32'h0,        4'hF, 32'hA5A5A5A5, 1'b0};

    model_clear();
    use_fast = 1'b0;
    rst = 1'b1;
    bus_psel = '0; bus_penable = 1'b0; bus_paddr = '0;
    bus_pwrite = 1'b0; bus_pwdata = '0; bus_pstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_pready", 32'(pready_m), 32'd0);
    check("reset_pslverr", 32'(pslverr_m), 32'd0);
    check("reset_prdata", prdata_m, 32'd0);
    check("reset_fast_pready", 32'(pready_f), 32'd0);
    @(posedge clk); #1;

    // Zero wait states: two-cycle transfers, write then read back-to-back.
    use_fast = 1'b1;
    run_txn("fast_rd0", 4'b0001, 8'h04, 1'b0, 32'h0, 4'hF);
    run_txn("fast_wr", 4'b1000, 8'h20, 1'b1, 32'h0BADCAFE, 4'hF);
    run_txn("fast_rdback", 4'b1000, 8'h20, 1'b0, 32'h0, 4'hF);
    idle(2);
    use_fast = 1'b0;

    for (int i = 0; i < 15; i++) begin
      model_xfer(0, tbl[i].sel, tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].st, e_rd, e_err);
      xfer(tbl[i].sel, tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].st, rd, er, lat);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(WS + 1));
      if (i % 3 == 2) idle(1);
    end

`ifdef APB_PSTRB_EN
    idle(1);
    model_xfer(0, 4'b1000, 8'h0C, 1'b1, 32'h11223344, 4'hF, e_rd, e_err);
    xfer(4'b1000, 8'h0C, 1'b1, 32'h11223344, 4'hF, rd, er, lat);
    model_xfer(0, 4'b1000, 8'h0C, 1'b1, 32'hAABBCCDD, 4'b0101, e_rd, e_err);
    xfer(4'b1000, 8'h0C, 1'b1, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    check("strb_partial_err", 32'(er), 32'd0);
    model_xfer(0, 4'b1000, 8'h0C, 1'b0, 32'h0, 4'h0, e_rd, e_err);
    xfer(4'b1000, 8'h0C, 1'b0, 32'h0, 4'h0, rd, er, lat);
    check("strb_merge_rdata", rd, 32'h11BB33DD);
    model_xfer(0, 4'b1000, 8'h0C, 1'b1, 32'hFFFFFFFF, 4'h0, e_rd, e_err);
    xfer(4'b1000, 8'h0C, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check("strb_zero_err", 32'(er), 32'd1);
    model_xfer(0, 4'b1000, 8'h0C, 1'b0, 32'h0, 4'hF, e_rd, e_err);
    xfer(4'b1000, 8'h0C, 1'b0, 32'h0, 4'hF, rd, er, lat);
    check("strb_zero_nowrite", rd, 32'h11BB33DD);
`endif

    // psel dropped during the wait state: transfer abandoned, no write, no pready.
    idle(1);
    run_txn("abort_pre", 4'b0001, 8'h10, 1'b1, 32'h00000011, 4'hF);
    bus_psel = 4'b0001; bus_penable = 1'b0; bus_paddr = 8'h10;
    bus_pwrite = 1'b1; bus_pwdata = 32'h00000099; bus_pstrb = 4'hF;
    @(posedge clk); #1 bus_penable = 1'b1;
    @(negedge clk);
    check("abort_wait_pready", 32'(pready_m), 32'd0);
    @(posedge clk); #1;
    bus_psel = '0; bus_penable = 1'b0;
    $display("txn %0d dut=ws2 aborted write bank0 addr=10 by dropping psel", ++n_txn);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_pready", 32'(pready_m), 32'd0);
      @(posedge clk); #1;
      bus_penable = (c % 2 == 0);
    end
    idle(1);
    run_txn("abort_readback", 4'b0001, 8'h10, 1'b0, 32'h0, 4'hF);

    idle(1);
    for (int i = 0; i < 150; i++) begin
      pick = $urandom_range(0, 99);
      rsel = (pick < 85) ? 4'(1 << $urandom_range(0, NS - 1)) : multi_tbl[$urandom_range(0, 4)];
      pick = $urandom_range(0, 99);
      if (pick < 70)      raddr = 8'($urandom_range(0, DEPTH - 1) * 4);
      else if (pick < 85) raddr = 8'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else                raddr = 8'($urandom_range(DEPTH, 63) * 4);
      run_txn($sformatf("rand%0d", i), rsel, raddr, 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // Reset during the wait state of a write: aborted and memory cleared.
    idle(1);
    bus_psel = 4'b0010; bus_penable = 1'b0; bus_paddr = 8'h14;
    bus_pwrite = 1'b1; bus_pwdata = 32'h5; bus_pstrb = 4'hF;
    @(posedge clk); #1 bus_penable = 1'b1;
    @(negedge clk);
    check("rstmid_wait_pready", 32'(pready_m), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    $display("txn %0d dut=ws2 write bank1 addr=14 data=5 interrupted by reset", ++n_txn);
    model_clear();
    @(negedge clk);
    check("rstmid_pready", 32'(pready_m), 32'd0);
    check("rstmid_pslverr", 32'(pslverr_m), 32'd0);
    check("rstmid_prdata", prdata_m, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_no_ready", 32'(pready_m), 32'd0);
    end
    @(posedge clk); #1;
    idle(1);
    run_txn("rstmid_readback", 4'b0010, 8'h14, 1'b0, 32'h0, 4'hF);
    run_txn("rst_cleared", 4'b0100, 8'h08, 1'b0, 32'h0, 4'hF);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
